// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder that steps a single fulladd cell once per clock.
// Optional signed-overflow output `ovf` is enabled by defining SERIAL_ADD_OVF_EN.

module fulladd (
    input  logic cin,
    input  logic x,
    input  logic y,
    output logic f,
    output logic cout
);
    assign f    = x ^ y ^ cin;
    assign cout = (x & y) | (cin & (x ^ y));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh, b_sh, s_sh, s_next;
    logic [CW-1:0]    cnt;
    logic             carry_q;
    logic             load, shift, last;
    logic             fa_f, fa_cout;

    fulladd u_fa (
        .cin  (carry_q),
        .x    (a_sh[0]),
        .y    (b_sh[0]),
        .f    (fa_f),
        .cout (fa_cout)
    );

    assign last   = (cnt == LAST);
    // New sum bit enters at the MSB; after WIDTH shifts bit 0 lines up with the LSB.
    assign s_next = WIDTH'({fa_f, s_sh} >> 1);
    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                shift = 1'b1;
                if (last) state_d = DONE;
            end
            DONE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            s_sh    <= '0;
            cnt     <= '0;
            carry_q <= 1'b0;
        end else if (load) begin
            a_sh    <= a;
            b_sh    <= b;
            carry_q <= cin;
            cnt     <= '0;
        end else if (shift) begin
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            s_sh    <= s_next;
            carry_q <= fa_cout;
            if (!last) cnt <= cnt + 1'b1;
        end
    end

    // Result registers move only on the final RUN edge, so partial sums never show.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
        end else if (shift && last) begin
            sum  <= s_next;
            cout <= fa_cout;
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    // carry_q here is the carry into the MSB; XOR with MSB carry-out gives signed overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              ovf <= 1'b0;
        else if (shift && last)  ovf <= carry_q ^ fa_cout;
    end
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: the driver predicts results and completion edges,
// a negedge monitor checks done/busy timing and the held sum/cout(/ovf) values.

module tb_serial_adder;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         cin = 1'b0;
    logic         busy, done, cout, ovf;
    logic [W-1:0] sum;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

`ifndef SERIAL_ADD_OVF_EN
    assign ovf = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
        int unsigned  e;
    } exp_t;

    exp_t         q[$];
    int           total = 0;
    int           bad = 0;
    int unsigned  edge_n = 0;
    int unsigned  next_free = 0;
    logic [W-1:0] last_sum = '0;
    logic         last_cout = 1'b0;
    logic         last_ovf = 1'b0;

    always @(posedge clk) edge_n++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, edge_n);
        end
    endtask

    // Reference: plain integer arithmetic, signed overflow from the range of the true sum.
    function automatic exp_t ref_add(input logic [W-1:0] av, input logic [W-1:0] bv,
                                     input logic c, input int unsigned e);
        exp_t r;
        int unsigned u;
        int sa, sb, st;
        u  = int'(av) + int'(bv) + int'(c);
        sa = $signed(av);
        sb = $signed(bv);
        st = sa + sb + int'(c);
        r.s = u[W-1:0];
        r.c = u[W];
        r.o = (st > (2 ** (W - 1)) - 1) || (st < -(2 ** (W - 1)));
        r.e = e;
        return r;
    endfunction

    // Present inputs for the next rising edge; record a prediction if it will be accepted.
    task automatic drive(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic c);
        start = s;
        a     = av;
        b     = bv;
        cin   = c;
        if (s && rst_n && (edge_n + 1 >= next_free)) begin
            q.push_back(ref_add(av, bv, c, edge_n + 1 + W));
            next_free = edge_n + 1 + W + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        drive(1'b0, W'($urandom), W'($urandom), 1'($urandom));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 4 * W && q.size() != 0; i++) drive_idle();
        if (q.size() != 0) begin
            chk("completion_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
    endtask

    task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic c);
        drive(1'b1, av, bv, c);
        wait_idle();
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        q.delete();
        next_free = 0;
        last_sum  = '0;
        last_cout = 1'b0;
        last_ovf  = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
        chk("rst_ovf", 32'(ovf), 32'd0);
`endif
    endtask

    logic exp_done, exp_busy;
    always @(negedge clk) begin
        exp_done = (q.size() != 0) && (q[0].e == edge_n);
        exp_busy = (q.size() != 0) && (edge_n + W >= q[0].e) && (edge_n < q[0].e);
        chk("done", 32'(done), 32'(exp_done));
        chk("busy", 32'(busy), 32'(exp_busy));
        if (exp_done) begin
            last_sum  = q[0].s;
            last_cout = q[0].c;
            last_ovf  = q[0].o;
            void'(q.pop_front());
        end
        chk("sum", 32'(sum), 32'(last_sum));
        chk("cout", 32'(cout), 32'(last_cout));
`ifdef SERIAL_ADD_OVF_EN
        chk("ovf", 32'(ovf), 32'(last_ovf));
`endif
    end

    initial begin
        #1;
        do_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        op(8'h5A, 8'h3C, 1'b0);
        op(8'hFF, 8'h01, 1'b0);
        op(8'hFF, 8'hFF, 1'b1);

        // start re-pulsed mid-RUN with different operands must be ignored
        drive(1'b1, 8'h01, 8'h01, 1'b0);
        drive_idle();
        drive_idle();
        drive(1'b1, 8'hAA, 8'h55, 1'b1);
        wait_idle();

        // start held high: second operation loads in the DONE cycle
        drive(1'b1, 8'h10, 8'h20, 1'b0);
        repeat (W) drive(1'b1, W'($urandom), W'($urandom), 1'($urandom));
        drive(1'b1, 8'h0F, 8'h01, 1'b0);
        wait_idle();

        // reset mid-RUN, then release with start already high
        drive(1'b1, 8'h55, 8'h11, 1'b0);
        repeat (3) drive_idle();
        do_reset();
        drive(1'b1, 8'h03, 8'h04, 1'b0);
        rst_n = 1'b1;
        drive(1'b1, 8'h03, 8'h04, 1'b0);
        wait_idle();

        op(8'h7F, 8'h01, 1'b0);
        op(8'h80, 8'h80, 1'b0);
        op(8'h40, 8'h20, 1'b0);
        op(8'h00, 8'h00, 1'b0);

        for (int i = 0; i < 400; i++)
            drive($urandom_range(0, 2) == 0, W'($urandom), W'($urandom), 1'($urandom));
        wait_idle();
        drive_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial multi-bit adder built around the existing single-bit `fulladd` cell (ports `cin`, `x`, `y`, `f`, `cout`).
- Sits directly upstream of `fulladd`:
  - feeds it one operand bit pair plus a registered carry each clock;
  - consumes its `f` and `cout` to build a WIDTH-bit sum.
- Trades area for latency: one `fulladd` instance, WIDTH cycles per addition.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; operands sampled on the edge where start=1 is accepted.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in for bit 0.
- busy  output  1  high while the addition is in progress (RUN state).
- done  output  1  one-cycle pulse: sum/cout valid.
- sum  output  WIDTH  result register.
- cout  output  1  carry out of bit WIDTH-1.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Internal shift registers, carry flop and bit counter cleared.
- Internal structure:
  - One `fulladd` instance with x=A_sh[0], y=B_sh[0], cin=carry_q.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 → load A_sh=a, B_sh=b, carry_q=cin, cnt=0; go to RUN.
  - start=0 → stay.
- RUN (busy=1), each edge:
  - S_sh <= {f, S_sh[WIDTH-1:1]}; A_sh, B_sh shift right by one; carry_q <= fulladd.cout; cnt <= cnt+1.
  - On the edge where cnt==WIDTH-1: sum <= {f, S_sh[WIDTH-1:1]}, cout <= fulladd.cout, state → DONE.
- DONE (done=1, busy=0), one cycle only:
  - start=1 → reload operands, go to RUN (back-to-back, no idle bubble).
  - start=0 → go to IDLE.
- Latency:
  - Start accepted at edge E0; done is high in the cycle following edge E0+WIDTH.
  - Throughput: one addition per WIDTH+1 cycles.
- Output stability:
  - sum and cout change only on the edge entering DONE.
  - They hold until the next completion or reset; partial results never appear on sum.
- Boundary conditions:
  - start while in RUN: ignored. Operands and carry are unaffected; no queuing.
  - a, b, cin changing while busy: no effect (captured at load).
  - WIDTH=1: RUN lasts exactly one edge.
  - cnt wraps only via reload; it never exceeds WIDTH-1.
  - rst_n asserted mid-RUN: immediate return to reset values; the in-flight operation is discarded and done is not pulsed.
  - rst_n deasserted with start=1 already high: the first rising edge after deassertion may accept start.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); exact for all inputs.

Optional Feature:
- Macro: SERIAL_ADD_OVF_EN
- Defined:
  - Adds output port `ovf` (1 bit), reset value 0, updated on the same edge as sum.
  - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1 (signed overflow).
  - Implementation: register carry_q captured before the final RUN edge.
- Undefined:
  - Port `ovf` is absent; no extra logic.
  - All other behaviour identical.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, cin=0, start pulse → done high exactly 8 edges after the accept edge; sum=0x96, cout=0; busy high for 8 cycles.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
- Start 0x01+0x01, re-pulse start with a=0xAA, b=0x55 at cycle 3 of RUN → ignored; sum=0x02, cout=0.
- Hold start=1 continuously with operands 0x10+0x20 then 0x0F+0x01 (changed in the DONE cycle) → two done pulses 9 cycles apart; sums 0x30 then 0x10; no IDLE cycle between.
- Assert rst_n=0 mid-RUN (cycle 4) → busy, done, sum, cout immediately 0. After release, 0x03+0x04 → sum=0x07.
- With SERIAL_ADD_OVF_EN: 0x7F+0x01 → sum=0x80, ovf=1, cout=0. 0x80+0x80 → sum=0x00, ovf=1, cout=1. 0x40+0x20 → ovf=0.
